// File: rtl/store_checker.sv
// Store checker: compares core data-memory stores against a preloaded table of expected (address, data) pairs.
// Optional feature: define STORE_CHECK_BYTE_MASK_EN to also match byte lanes (byteEnable vs exp_mask).
module store_checker #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       CNT_W     = 8,
  parameter int unsigned       TIMEOUT   = 4096,
  parameter logic [DATA_W-1:0] SENT_ADDR = 96,
  parameter logic [DATA_W-1:0] SENT_DATA = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [DATA_W-1:0]        DataAdr,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [3:0]               byteEnable,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_idx,
  input  logic [DATA_W-1:0]        exp_addr,
  input  logic [DATA_W-1:0]        exp_data,
  input  logic [3:0]               exp_mask,
  input  logic [CNT_W-1:0]         exp_num,
  input  logic                     any_order,
  input  logic                     start,
  input  logic                     clear,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         pass_count,
  output logic [1:0]               fail_code,
  output logic [DATA_W-1:0]        fail_addr,
  output logic [DATA_W-1:0]        fail_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISHED} state_e;

  state_e              state, stateNext;
  logic [CNT_W-1:0]    expNum, expNumNext;
  logic                anyOrd, anyOrdNext;
  logic [CNT_W-1:0]    ptr, ptrNext;
  logic [DEPTH-1:0]    hit, hitNext;
  logic [TMO_W-1:0]    tmo, tmoNext;
  logic                doneNext, passNext;
  logic [CNT_W-1:0]    passCountNext;
  logic [1:0]          failCodeNext;
  logic [DATA_W-1:0]   failAddrNext, failDataNext;

  logic [DATA_W-1:0]   tblAddr [DEPTH];
  logic [DATA_W-1:0]   tblData [DEPTH];
  logic [DEPTH-1:0]    entryHit;
  logic                found, inOrdOk, isSent, isScratch;
  logic [IDX_W-1:0]    foundIdx;

`ifdef STORE_CHECK_BYTE_MASK_EN
  logic [3:0]          tblMask [DEPTH];

  function automatic logic [DATA_W-1:0] laneBits(input logic [3:0] mk);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < DATA_W; b++) m[b] = mk[2'((b / 8) % 4)];
    return m;
  endfunction
`else
  logic unusedLanes;
  assign unusedLanes = ^{byteEnable, exp_mask};
`endif

  // Table contents survive reset; only the run bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (exp_we && state == IDLE) begin
      tblAddr[exp_idx] <= exp_addr;
      tblData[exp_idx] <= exp_data;
`ifdef STORE_CHECK_BYTE_MASK_EN
      tblMask[exp_idx] <= exp_mask;
`endif
    end
  end

  always_comb begin
    entryHit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef STORE_CHECK_BYTE_MASK_EN
      entryHit[IDX_W'(i)] = (DataAdr == tblAddr[IDX_W'(i)]) &&
                            (byteEnable == tblMask[IDX_W'(i)]) &&
                            (((WriteData ^ tblData[IDX_W'(i)]) & laneBits(tblMask[IDX_W'(i)])) == '0);
`else
      entryHit[IDX_W'(i)] = (DataAdr == tblAddr[IDX_W'(i)]) && (WriteData == tblData[IDX_W'(i)]);
`endif
    end
  end

  // Any-order: lowest valid entry not yet consumed wins.
  always_comb begin
    found    = 1'b0;
    foundIdx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && (32'(expNum) > i) && !hit[IDX_W'(i)] && entryHit[IDX_W'(i)]) begin
        found    = 1'b1;
        foundIdx = IDX_W'(i);
      end
    end
    inOrdOk   = (ptr < expNum) && entryHit[ptr[IDX_W-1:0]];
    isScratch = (DataAdr == SENT_ADDR);
    isSent    = isScratch && (WriteData == SENT_DATA);
  end

  always_comb begin
    stateNext     = state;
    expNumNext    = expNum;
    anyOrdNext    = anyOrd;
    ptrNext       = ptr;
    hitNext       = hit;
    tmoNext       = tmo;
    doneNext      = done;
    passNext      = pass;
    passCountNext = pass_count;
    failCodeNext  = fail_code;
    failAddrNext  = fail_addr;
    failDataNext  = fail_data;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext     = RUN;
          expNumNext    = exp_num;
          anyOrdNext    = any_order;
          ptrNext       = '0;
          hitNext       = '0;
          tmoNext       = '0;
          doneNext      = 1'b0;
          passNext      = 1'b0;
          passCountNext = '0;
          failCodeNext  = 2'd0;
          failAddrNext  = '0;
          failDataNext  = '0;
        end
      end
      RUN: begin
        if (MemWrite) begin
          tmoNext = '0;
          if (isSent) begin
            stateNext = FINISHED;
            doneNext  = 1'b1;
            if (pass_count == expNum) passNext = 1'b1;
            else failCodeNext = 2'd2;
          end else if (!isScratch) begin
            if (anyOrd ? found : inOrdOk) begin
              if (anyOrd) hitNext[foundIdx] = 1'b1;
              else ptrNext = ptr + 1'b1;
              if (pass_count != '1) passCountNext = pass_count + 1'b1;
            end else begin
              stateNext    = FINISHED;
              doneNext     = 1'b1;
              failCodeNext = 2'd1;
              failAddrNext = DataAdr;
              failDataNext = WriteData;
            end
          end
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          stateNext    = FINISHED;
          doneNext     = 1'b1;
          failCodeNext = 2'd3;
        end else begin
          tmoNext = tmo + 1'b1;
        end
      end
      FINISHED: begin
        if (clear) begin
          stateNext     = IDLE;
          doneNext      = 1'b0;
          passNext      = 1'b0;
          passCountNext = '0;
          failCodeNext  = 2'd0;
          failAddrNext  = '0;
          failDataNext  = '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      expNum     <= '0;
      anyOrd     <= 1'b0;
      ptr        <= '0;
      hit        <= '0;
      tmo        <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_count <= '0;
      fail_code  <= 2'd0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      state      <= stateNext;
      expNum     <= expNumNext;
      anyOrd     <= anyOrdNext;
      ptr        <= ptrNext;
      hit        <= hitNext;
      tmo        <= tmoNext;
      done       <= doneNext;
      pass       <= passNext;
      pass_count <= passCountNext;
      fail_code  <= failCodeNext;
      fail_addr  <= failAddrNext;
      fail_data  <= failDataNext;
    end
  end

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: directed vector table, timeout/reset sequences and randomized runs vs a queue model.
module tb_store_checker;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0, WriteData = '0;
  logic [3:0]  byteEnable = 4'hF;
  logic        exp_we = 1'b0;
  logic [5:0]  exp_idx = '0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic [3:0]  exp_mask = 4'hF;
  logic [7:0]  exp_num = '0;
  logic        any_order = 1'b0, start = 1'b0, clear = 1'b0;
  logic        done, pass;
  logic [7:0]  pass_count;
  logic [1:0]  fail_code;
  logic [31:0] fail_addr, fail_data;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  store_checker #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .byteEnable(byteEnable), .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_mask(exp_mask), .exp_num(exp_num), .any_order(any_order),
    .start(start), .clear(clear), .done(done), .pass(pass), .pass_count(pass_count),
    .fail_code(fail_code), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  typedef struct packed {
    logic             anyOrd;
    logic [7:0]       num;
    logic [3:0]       ns;
    logic [5:0][31:0] sa;
    logic [5:0][31:0] sd;
    logic             eDone;
    logic             ePass;
    logic [7:0]       eCnt;
    logic [1:0]       eCode;
    logic [31:0]      eAddr;
    logic [31:0]      eData;
  } vec_t;

  vec_t vecs [NV];
  logic [63:0] rTbl[$];
  logic [63:0] rSt[$];
  int          ord[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic checkAll(input string tag, input bit eDone, input bit ePass, input int eCnt,
                          input int eCode, input logic [31:0] eA, input logic [31:0] eD);
    check({tag, ".done"}, done, eDone);
    check({tag, ".pass"}, pass, ePass);
    check({tag, ".pass_count"}, pass_count, eCnt);
    check({tag, ".fail_code"}, fail_code, eCode);
    check({tag, ".fail_addr"}, fail_addr, eA);
    check({tag, ".fail_data"}, fail_data, eD);
  endtask

  task automatic loadEntry(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    exp_we = 1'b1; exp_idx = 6'(idx); exp_addr = a; exp_data = d; exp_mask = m;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic doStore(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic startRun(input int num, input bit ao);
    exp_num = 8'(num); any_order = ao; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearRun();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic setVec(input int v, input bit ao, input int num, input bit eDone, input bit ePass,
                        input int eCnt, input int eCode, input logic [31:0] eA, input logic [31:0] eD);
    vecs[v] = '0;
    vecs[v].anyOrd = ao; vecs[v].num = 8'(num);
    vecs[v].eDone = eDone; vecs[v].ePass = ePass; vecs[v].eCnt = 8'(eCnt);
    vecs[v].eCode = 2'(eCode); vecs[v].eAddr = eA; vecs[v].eData = eD;
  endtask

  task automatic addStore(input int v, input logic [31:0] a, input logic [31:0] d);
    vecs[v].sa[vecs[v].ns] = a;
    vecs[v].sd[vecs[v].ns] = d;
    vecs[v].ns = vecs[v].ns + 4'd1;
  endtask

  // Reference: expected pairs as a list; in-order consumes the head, any-order removes the first equal pair.
  function automatic void model(input bit ao, input logic [63:0] tbl[$], input logic [63:0] st[$],
                                output bit mDone, output bit mPass, output int mCnt, output int mCode,
                                output logic [31:0] mA, output logic [31:0] mD);
    logic [63:0] rem[$];
    rem = tbl;
    mDone = 0; mPass = 0; mCnt = 0; mCode = 0; mA = '0; mD = '0;
    foreach (st[k]) begin
      int pos;
      logic [31:0] a, d;
      a = st[k][63:32];
      d = st[k][31:0];
      pos = -1;
      if (mDone) break;
      if (a == 32'd96 && d == 32'd30) begin
        mDone = 1;
        if (mCnt == tbl.size()) mPass = 1;
        else mCode = 2;
      end else if (a != 32'd96) begin
        if (ao) begin
          for (int j = 0; j < rem.size(); j++) if (pos < 0 && rem[j] == st[k]) pos = j;
        end else if (rem.size() > 0 && rem[0] == st[k]) begin
          pos = 0;
        end
        if (pos >= 0) begin
          rem.delete(pos);
          mCnt++;
        end else begin
          mDone = 1; mCode = 1; mA = a; mD = d;
        end
      end
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          mDone, mPass, ao;
    int          mCnt, mCode, n, roll, tmp, sw;
    logic [31:0] mA, mD, a, d;

    // Directed vectors against table (100,25),(104,4096),(108,4184)
    setVec(0, 0, 3, 1, 1, 3, 0, 0, 0);
    addStore(0, 100, 25); addStore(0, 104, 4096); addStore(0, 108, 4184); addStore(0, 96, 30);
    setVec(1, 0, 3, 1, 0, 1, 1, 104, 4097);
    addStore(1, 100, 25); addStore(1, 104, 4097); addStore(1, 108, 4184);
    setVec(2, 1, 3, 1, 1, 3, 0, 0, 0);
    addStore(2, 108, 4184); addStore(2, 100, 25); addStore(2, 104, 4096); addStore(2, 96, 30);
    setVec(3, 1, 3, 1, 0, 1, 1, 100, 25);
    addStore(3, 100, 25); addStore(3, 100, 25);
    setVec(4, 0, 3, 1, 0, 2, 2, 0, 0);
    addStore(4, 100, 25); addStore(4, 96, 7); addStore(4, 104, 4096); addStore(4, 96, 30);
    setVec(5, 0, 0, 1, 1, 0, 0, 0, 0);
    addStore(5, 96, 30);
    setVec(6, 0, 3, 1, 0, 3, 1, 112, 1);
    addStore(6, 100, 25); addStore(6, 104, 4096); addStore(6, 108, 4184); addStore(6, 112, 1);
    setVec(7, 0, 3, 1, 0, 0, 1, 104, 4096);
    addStore(7, 104, 4096); addStore(7, 100, 25);

    tick(); tick();
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    loadEntry(0, 100, 25, 4'hF);
    loadEntry(1, 104, 4096, 4'hF);
    loadEntry(2, 108, 4184, 4'hF);

    for (int v = 0; v < NV; v++) begin
      startRun(int'(vecs[v].num), vecs[v].anyOrd);
      for (int k = 0; k < int'(vecs[v].ns); k++) doStore(vecs[v].sa[k], vecs[v].sd[k]);
      checkAll($sformatf("vec%0d", v), vecs[v].eDone, vecs[v].ePass, int'(vecs[v].eCnt),
               int'(vecs[v].eCode), vecs[v].eAddr, vecs[v].eData);
      clearRun();
      check($sformatf("vec%0d.cleared", v), done, 0);
    end

    // Timeout with no stores: fires on the 16th edge after start
    startRun(3, 0);
    repeat (15) tick();
    check("tmo.early", done, 0);
    tick();
    checkAll("tmo", 1, 0, 0, 3, 0, 0);
    clearRun();

    // Scratch store restarts the timeout
    startRun(3, 0);
    repeat (10) tick();
    doStore(96, 7);
    repeat (15) tick();
    check("tmo2.early", done, 0);
    tick();
    checkAll("tmo2", 1, 0, 0, 3, 0, 0);
    clearRun();

    // Mid-run reset clears everything; table survives
    startRun(3, 0);
    doStore(100, 25);
    check("midrst.pre", pass_count, 1);
    reset = 1'b0;
    tick();
    checkAll("midrst", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    doStore(100, 25);
    check("idle.store_ignored", pass_count, 0);
    startRun(3, 0);
    doStore(100, 25); doStore(104, 4096); doStore(108, 4184); doStore(96, 30);
    checkAll("after_rst", 1, 1, 3, 0, 0, 0);
    clearRun();

    // Table write on the same edge as start is used by that run
    exp_we = 1'b1; exp_idx = 6'd0; exp_addr = 32'd200; exp_data = 32'd77; exp_mask = 4'hF;
    startRun(1, 0);
    exp_we = 1'b0;
    doStore(200, 77);
    doStore(96, 30);
    checkAll("same_edge", 1, 1, 1, 0, 0, 0);
    clearRun();

`ifdef STORE_CHECK_BYTE_MASK_EN
    loadEntry(0, 300, 32'hAA, 4'b0001);
    startRun(1, 0);
    byteEnable = 4'b0001;
    doStore(300, 32'h123456AA);
    byteEnable = 4'hF;
    check("mask.match", pass_count, 1);
    doStore(96, 30);
    check("mask.pass", pass, 1);
    clearRun();
    startRun(1, 0);
    byteEnable = 4'b0011;
    doStore(300, 32'h123456AA);
    byteEnable = 4'hF;
    check("mask.bad_lanes.code", fail_code, 1);
    check("mask.bad_lanes.addr", fail_addr, 300);
    clearRun();
`endif

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      rTbl.delete(); rSt.delete(); ord.delete();
      n  = int'($urandom_range(0, 8));
      ao = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        a = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
        d = $urandom;
        rTbl.push_back({a, d});
        loadEntry(i, a, d, 4'hF);
        ord.push_back(i);
      end
      if (ao) begin
        for (int i = n - 1; i > 0; i--) begin
          sw = int'($urandom_range(0, i));
          tmp = ord[i]; ord[i] = ord[sw]; ord[sw] = tmp;
        end
      end
      foreach (ord[j]) begin
        roll = int'($urandom_range(0, 15));
        if (roll == 2) break;
        if (roll == 0) begin
          rSt.push_back({32'h8000 + 32'($urandom_range(0, 255)) * 4, 32'($urandom)});
        end else begin
          if (roll == 1) begin
            d = $urandom;
            if (d == 32'd30) d = 32'd31;
            rSt.push_back({32'd96, d});
          end
          rSt.push_back(rTbl[ord[j]]);
          if (roll == 3 && ao) rSt.push_back(rTbl[ord[j]]);
        end
      end
      rSt.push_back({32'd96, 32'd30});

      startRun(n, ao);
      foreach (rSt[k]) begin
        repeat ($urandom_range(0, 3)) tick();
        doStore(rSt[k][63:32], rSt[k][31:0]);
      end
      model(ao, rTbl, rSt, mDone, mPass, mCnt, mCode, mA, mD);
      checkAll($sformatf("rand%0d", r), mDone, mPass, mCnt, mCode, mA, mD);
      clearRun();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable self-check block that monitors the data-memory write bus of the RISC-V core and compares every store against a preloaded table of expected (address, data) pairs. It generalises the bench-level store checker: parametrised depth and widths, in-order or any-order matching, sentinel-terminated runs, a no-store timeout, and a sticky first-failure record. It sits beside `top` in simulation and FPGA builds, tapping `MemWrite`, `DataAdr`, `WriteData` and `byteEnable`.

## Interface
- `DATA_W`, 32, store data / address width
- `DEPTH`, 64, expected-table entries (power of two)
- `CNT_W`, 8, width of pass counter and `exp_num`
- `TIMEOUT`, 4096, cycles without a store in RUN before a timeout failure
- `SENT_ADDR`, 96, sentinel store address
- `SENT_DATA`, 30, sentinel store data

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `MemWrite`  in  1  core store strobe
- `DataAdr`  in  DATA_W  store address
- `WriteData`  in  DATA_W  store data
- `byteEnable`  in  4  store byte lanes
- `exp_we`  in  1  table write strobe, honoured in IDLE only
- `exp_idx`  in  log2(DEPTH)  table write index
- `exp_addr`, `exp_data`  in  DATA_W  expected pair
- `exp_mask`  in  4  expected byte lanes
- `exp_num`  in  CNT_W  number of valid entries, latched on `start`
- `any_order`  in  1  matching mode, latched on `start`
- `start`  in  1  arm checker (IDLE only)
- `clear`  in  1  return from DONE to IDLE, table kept
- `done`  out  1  run finished
- `pass`  out  1  run finished with no failure
- `pass_count`  out  CNT_W  matched stores
- `fail_code`  out  2  0 none, 1 unexpected/mismatch, 2 missing at sentinel, 3 timeout
- `fail_addr`, `fail_data`  out  DATA_W  first offending store (0 for codes 2/3)

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> DONE on sentinel, on any failure, or on timeout; DONE -> IDLE on `clear`. `start` outside IDLE and `clear` outside DONE ignored.
- Store event = `MemWrite`=1 sampled in RUN. Stores outside RUN ignored.
- Sentinel: `DataAdr`==SENT_ADDR and `WriteData`==SENT_DATA. Checked before table matching. `pass`=1 iff no failure and `pass_count`==latched `exp_num`; else `fail_code`=2.
- Store to SENT_ADDR with non-sentinel data: ignored (scratch location), no counting, resets timeout.
- In-order mode: compare against entry[ptr], ptr starts 0; match -> ptr++, `pass_count`++; mismatch or ptr==`exp_num` -> `fail_code`=1, DONE.
- Any-order mode: match lowest-index entry < `exp_num` with hit bit clear; set hit bit, `pass_count`++. No match (including repeat of an already-hit pair) -> `fail_code`=1, DONE.
- Failure is sticky: first failure records code/addr/data; later events cannot overwrite.
- Timeout counter clears on every store event and on entering RUN; reaching TIMEOUT -> `fail_code`=3, DONE.
- `pass_count` saturates at all-ones.

## Timing
- All outputs registered; effect of a store visible the cycle after the sampling edge.
- Store in the same cycle as `start` is not checked.
- `exp_we` on same edge as `start`: write takes effect, entry usable in the run.
- Reset (`reset`=0) at any time, including mid-run: state IDLE, `done`=0, `pass`=0, `pass_count`=0, `fail_code`=0, `fail_addr`=`fail_data`=0, ptr=0, hit bits cleared, timeout 0. Table data not reset.
- `exp_num`=0 then sentinel: `pass`=1.

## Configuration
- `STORE_CHECK_BYTE_MASK_EN` defined: match additionally requires `byteEnable`==`exp_mask`, and data compared only on enabled lanes.
- Undefined: `byteEnable` and `exp_mask` ignored; full-word address and data compare.

## Test plan
- Load 3 in-order entries (100,25),(104,4096),(108,4184), `exp_num`=3, issue them then (96,30) -> `done`=1, `pass`=1, `pass_count`=3.
- Same table, store (104,4097) second -> `fail_code`=1, `fail_addr`=104, `fail_data`=4097, `pass_count`=1.
- Any-order, issue (108,4184),(100,25),(104,4096),(96,30) -> `pass`=1; repeat (100,25) twice -> `fail_code`=1.
- `exp_num`=3, only two matches then sentinel -> `fail_code`=2, `pass`=0; store (96,7) mid-run -> ignored.
- TIMEOUT=16, start, no stores -> `fail_code`=3 on cycle 16 after start; assert `reset`=0 mid-run -> all outputs 0 next cycle.
- With macro: entry mask 4'b0001 data 0xAA, store 0x123456AA mask 4'b0001 -> match; mask 4'b0011 -> `fail_code`=1.
